// File: rtl/seq_arith_unit.sv
// seq_arith_unit: shared multi-cycle add/sub/mul/div/mod/exp engine.
// start/busy/done handshake; 2*WIDTH-bit result plus status flags.
module seq_arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         Command,
  input  logic [WIDTH-1:0]   inputP,
  input  logic [WIDTH-1:0]   inputQ,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               divideByZero,
  output logic               error
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_EXP = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]      op;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] rem;
  logic [RW-1:0]   pa;
  logic [RW-1:0]   acc;
  logic            base_ovf;
  logic            c_s;
  logic            ov_s;
  logic            dz_s;
  logic            er_s;

  logic is_add, is_sub, is_mul;
  logic is_div, is_mod, is_exp;
  logic is_bad;
  logic q_zero;
  logic single;
  logic accept, step;
  logic finish, commit;

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  dif;
  logic [WIDTH:0]  rem_sh;
  logic [WIDTH:0]  trial;
  logic [2*RW-1:0] prod;
  logic [2*RW-1:0] sq;

  always_comb begin
    is_add = 1'b0;
    is_sub = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    is_mod = 1'b0;
    is_exp = 1'b0;
    is_bad = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): is_add = 1'b1;
      (op == OP_SUB): is_sub = 1'b1;
      (op == OP_MUL): is_mul = 1'b1;
      (op == OP_DIV): is_div = 1'b1;
      (op == OP_MOD): is_mod = 1'b1;
      (op == OP_EXP): is_exp = 1'b1;
      default:        is_bad = 1'b1;
    endcase
  end

  assign q_zero = (q_reg == '0);
  assign single = is_add | is_sub | is_bad
                | ((is_div | is_mod) & q_zero);

  assign sum = {1'b0, pa[WIDTH-1:0]}
             + {1'b0, q_reg};
  assign dif = {1'b0, pa[WIDTH-1:0]}
             - {1'b0, q_reg};

  // restoring division: top bit of trial is set when it would go negative
  assign rem_sh = {rem, mp[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, q_reg};

  assign prod = {{RW{1'b0}}, acc}
              * {{RW{1'b0}}, pa};
  assign sq   = {{RW{1'b0}}, pa}
              * {{RW{1'b0}}, pa};

  // the done cycle still counts as busy
  assign busy = (state != IDLE) | done;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        if (single || cnt == '0) begin
          finish  = 1'b1;
          state_n = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op           <= '0;
      cnt          <= '0;
      q_reg        <= '0;
      mp           <= '0;
      rem          <= '0;
      pa           <= '0;
      acc          <= '0;
      base_ovf     <= 1'b0;
      c_s          <= 1'b0;
      ov_s         <= 1'b0;
      dz_s         <= 1'b0;
      er_s         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      carry        <= 1'b0;
      overflow     <= 1'b0;
      divideByZero <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= commit;

      if (accept) begin
        op    <= Command;
        q_reg <= inputQ;
        pa    <= {{WIDTH{1'b0}}, inputP};
        // divide shifts the dividend; mul/exp shift Q
        if (Command == OP_DIV || Command == OP_MOD)
          mp <= inputP;
        else
          mp <= inputQ;
        if (Command == OP_EXP)
          acc <= {{(RW-1){1'b0}}, 1'b1};
        else
          acc <= '0;
        rem          <= '0;
        cnt          <= CW'(WIDTH);
        base_ovf     <= 1'b0;
        c_s          <= 1'b0;
        ov_s         <= 1'b0;
        dz_s         <= 1'b0;
        er_s         <= 1'b0;
        result       <= '0;
        carry        <= 1'b0;
        overflow     <= 1'b0;
        divideByZero <= 1'b0;
        error        <= 1'b0;
      end

      if (step) begin
        cnt <= cnt - CW'(1);
        if (is_mul) begin
          if (mp[0]) acc <= acc + pa;
          pa <= pa << 1;
          mp <= mp >> 1;
        end else if (is_exp) begin
          if (mp[0]) begin
            acc <= prod[RW-1:0];
            if (base_ovf || (|prod[2*RW-1:RW]))
              ov_s <= 1'b1;
          end
          pa       <= sq[RW-1:0];
          base_ovf <= base_ovf | (|sq[2*RW-1:RW]);
          mp       <= mp >> 1;
        end else begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            mp  <= {mp[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            mp  <= {mp[WIDTH-2:0], 1'b0};
          end
        end
      end

      if (finish) begin
        if (is_add) begin
          acc  <= {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
          c_s  <= sum[WIDTH];
          ov_s <= (pa[WIDTH-1] == q_reg[WIDTH-1])
                && (sum[WIDTH-1] != pa[WIDTH-1]);
        end else if (is_sub) begin
          acc  <= {{WIDTH{1'b0}}, dif[WIDTH-1:0]};
          c_s  <= dif[WIDTH];
          ov_s <= (pa[WIDTH-1] != q_reg[WIDTH-1])
                && (dif[WIDTH-1] != pa[WIDTH-1]);
        end else if (is_bad) begin
          acc  <= '0;
          er_s <= 1'b1;
        end else if ((is_div || is_mod) && q_zero) begin
          acc  <= '1;
          dz_s <= 1'b1;
        end else if (is_div) begin
          acc <= {{WIDTH{1'b0}}, mp};
        end else if (is_mod) begin
          acc <= {{WIDTH{1'b0}}, rem};
        end
      end

      if (commit) begin
        result       <= acc;
        carry        <= c_s;
        overflow     <= ov_s;
        divideByZero <= dz_s;
        error        <= er_s;
      end
    end
  end

endmodule
